seq_restoring_divider: RTL

- Iterative unsigned restoring divider: DIVIDEND_W-bit dividend ÷ DIVISOR_W-bit divisor → quotient + remainder.
- Inverse operator to the team's 4x4 array multiplier. Sits in the same TinyTapeout user-project wrapper, driven from ui_in/uio_in with results on uo_out/uio_out.
- One quotient bit per clock.
- start/busy/out_valid handshake.

---
 rtl/seq_restoring_divider_if.sv | 25 ++
 rtl/seq_restoring_divider.sv | 127 ++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider_if.sv
// Handshake and operand/result bundle for seq_restoring_divider.
// master: the block issuing divide requests; slave: the divider itself.
interface seq_restoring_divider_if #(
    parameter int unsigned DIVIDEND_W = 8,
    parameter int unsigned DIVISOR_W  = 4
) ();
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  out_valid;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Optional build macro DIV_EARLY_OUT_EN: when the dividend is smaller than a
// non-zero divisor, the result is produced one cycle after start without iterating.
module seq_restoring_divider #(
    parameter int unsigned DIVIDEND_W = 8,
    parameter int unsigned DIVISOR_W  = 4
) (
    input logic                    clk,
    input logic                    rst,
    seq_restoring_divider_if.slave bus
);
    localparam int unsigned CntW = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e                state_q, state_d;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    logic [DIVIDEND_W-1:0] dq_q, dq_d;
    logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
    // Stored remainder is always < divisor, so DIVISOR_W bits suffice; the
    // extra bit only exists in the shifted trial value below.
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  out_valid_q, out_valid_d;
    logic                  dbz_q, dbz_d;
    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;

    logic [DIVISOR_W:0]    shifted;
    logic                  q_bit;

    // Next-state: operand capture, one restoring step per cycle, result hold.
    always_comb begin
        state_d     = state_q;
        dq_d        = dq_q;
        divisor_d   = divisor_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        dbz_d       = dbz_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        shifted = {rem_q, dq_q[DIVIDEND_W-1]};
        q_bit   = (shifted >= {1'b0, divisor_q});

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    dq_d        = bus.dividend;
                    divisor_d   = bus.divisor;
                    out_valid_d = 1'b0;
                    dbz_d       = 1'b0;
                    if (bus.divisor == '0) begin
                        state_d     = StDone;
                        out_valid_d = 1'b1;
                        dbz_d       = 1'b1;
                        quotient_d  = '1;
                        remainder_d = bus.dividend[DIVISOR_W-1:0];
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (bus.dividend < DIVIDEND_W'(bus.divisor)) begin
                        state_d     = StDone;
                        out_valid_d = 1'b1;
                        quotient_d  = '0;
                        remainder_d = bus.dividend[DIVISOR_W-1:0];
                    end
`endif
                    else begin
                        state_d = StCalc;
                        rem_d   = '0;
                        cnt_d   = CntW'(DIVIDEND_W - 1);
                    end
                end
            end
            StCalc: begin
                // Modular subtract is exact: the true difference is < divisor.
                rem_d = q_bit ? (shifted[DIVISOR_W-1:0] - divisor_q) : shifted[DIVISOR_W-1:0];
                dq_d  = {dq_q[DIVIDEND_W-2:0], q_bit};
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == '0) begin
                    state_d     = StDone;
                    out_valid_d = 1'b1;
                    quotient_d  = dq_d;
                    remainder_d = rem_d;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StCalc);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            dq_q        <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            dq_q        <= dq_d;
            divisor_q   <= divisor_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            dbz_q       <= dbz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule
